if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Holds the program counter, the instruction memory and its loader write port. Each cycle it presents the fetched word and PC+4 to IF/ID, applies stalls from the hazard unit and branch/jump redirects resolved in ID, and raises the IF/ID flush on a redirect. It also detects the HALT word and freezes fetch.

## Interface
- IMEM_WORDS, 256: instruction memory depth in 32-bit words; power of two; AW = log2(IMEM_WORDS).
- RESET_PC, 32'h0000_0000: PC value after reset; word aligned.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = fetch enabled; 0 = fetch held (program load / debug).
- stall  in  1  hazard-unit stall; PC and fetch counter hold.
- branch_taken  in  1  taken branch resolved in ID this cycle.
- branch_target  in  32  branch target byte address.
- jump  in  1  jump resolved in ID this cycle.
- jump_target  in  32  jump target byte address.
- load_we  in  1  loader write strobe.
- load_addr  in  AW  loader word address.
- load_data  in  32  loader write word.
- if_pc  out  32  current PC.
- if_pc_plus_4  out  32  if_pc + 4, to IF/ID.
- if_instruction  out  32  fetched word, to IF/ID.
- flush_ifid  out  1  redirect accepted; IF/ID must squash its next load.
- halted  out  1  HALT executed; fetch frozen until reset.
- fetch_count  out  32  count of accepted fetches.

## Operation
- Memory: IMEM_WORDS x 32. Synchronous write, asynchronous read at word index pc[AW+1:2]. Contents are not affected by reset.
- Out-of-range PC: if pc[31:AW+2] != 0, the fetched word is 32'h0 (NOP).
- Loader: a write occurs only when load_we=1 and run=0. It is ignored when run=1.
- active = run & !halted.
- if_instruction:
  - 0 when !active;
  - 0 when the fetched word is HALT (32'hFFFF_FFFF);
  - otherwise the memory word.
- redirect = active & !stall & (branch_taken | jump).
  - When both are asserted, jump wins.
  - Target bits [1:0] are forced to 0.
- Next-PC priority, highest first:
  - reset -> RESET_PC;
  - !active -> hold;
  - stall -> hold (any redirect in the same cycle is ignored; ID re-asserts it after the stall);
  - redirect -> target;
  - HALT word fetched -> hold, and set halted;
  - otherwise pc + 4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
- HALT fetched in the same cycle as a redirect is a wrong-path fetch: the redirect is taken and halted is not set.
- halted is sticky. Only reset clears it; run has no effect on it.
- flush_ifid = redirect (combinational).
- fetch_count increments by 1 (wrapping) on every cycle where active & !stall, including redirect cycles and the HALT cycle.

## Timing
- Reset values:
  - pc = RESET_PC, so if_pc = RESET_PC and if_pc_plus_4 = RESET_PC+4;
  - halted = 0, fetch_count = 0;
  - flush_ifid = 0 and if_instruction = 0 (while run = 0).
- Reset asserted mid-run takes effect immediately (asynchronous). Memory contents are preserved.
- Latency:
  - PC update: 1 cycle.
  - if_instruction / if_pc_plus_4 follow pc combinationally in the same cycle, so IF/ID captures them on the next edge.
- Redirect penalty: one squashed slot. flush_ifid is high in the cycle the target is selected; the target word is presented in the following cycle.
- Load then read: a word written at edge N is readable from cycle N+1.
- run 0->1: fetch starts from the held PC in the same cycle.
- run 1->0: PC holds on the next edge; the output becomes NOP immediately.
- halted rises on the edge after the HALT fetch. if_pc stays at the HALT address.

## Test plan
- Load words at addresses 0..3, raise run -> if_pc sequence 0,4,8,12 on consecutive cycles; words match; fetch_count = 4 after 4 cycles.
- run=1, load_we=1, load_addr=0, load_data=32'hDEAD_BEEF -> memory word 0 unchanged.
- stall high for 3 cycles at pc=8 -> if_pc holds at 8; fetch_count holds; a branch_taken raised during the stall gives no redirect and flush_ifid stays 0.
- At pc=4: branch_taken=1, branch_target=32'h42 -> flush_ifid=1 that cycle; next if_pc=32'h40.
- At pc=4: branch_taken=1 and jump=1 together -> jump_target is taken.
- HALT word at address 5 -> if_instruction=0 at pc=20; halted=1 next cycle; pc frozen at 20. Clearing run, then reasserting it, keeps halted=1. reset low clears halted and pc returns to RESET_PC.
- HALT fetched together with a redirect -> target taken; halted stays 0.
- With IMEM_WORDS=256, jump to 32'h400 -> if_instruction=0 (out of range), PC continues incrementing from 32'h400.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, the instruction memory and its loader port. Each cycle it
// presents the fetched word and PC+4 to IF/ID, honours hazard stalls and
// ID-resolved branch/jump redirects, and freezes fetch on the HALT word.
module if_fetch_stage #(
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [31:0]                   branch_target,
    input  logic                          jump,
    input  logic [31:0]                   jump_target,
    input  logic                          load_we,
    input  logic [$clog2(IMEM_WORDS)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    output logic [31:0]                   if_pc,
    output logic [31:0]                   if_pc_plus_4,
    output logic [31:0]                   if_instruction,
    output logic                          flush_ifid,
    output logic                          halted,
    output logic [31:0]                   fetch_count
);

    localparam int          AW        = $clog2(IMEM_WORDS);
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    logic [31:0] r_mem [IMEM_WORDS];
    logic [31:0] r_pc;
    logic        r_halted;
    logic [31:0] r_fetch_count;

    logic        w_active;
    logic        w_advance;
    logic        w_redirect;
    logic        w_in_range;
    logic [31:0] w_mem_word;
    logic        w_is_halt;
    logic [31:0] w_pc_plus_4;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;
    logic        w_set_halted;

    // Fetch is live only while running and not halted; a stall freezes it.
    assign w_active   = run & ~r_halted;
    assign w_advance  = w_active & ~stall;
    assign w_redirect = w_advance & (branch_taken | jump);

    // Addresses beyond the memory fetch a NOP rather than aliasing.
    assign w_in_range  = (r_pc[31:AW+2] == '0);
    assign w_mem_word  = w_in_range ? r_mem[r_pc[AW+1:2]] : 32'h0;
    assign w_is_halt   = (w_mem_word == HALT_WORD);
    assign w_pc_plus_4 = r_pc + 32'd4;

    // Jump has priority over branch; targets are forced word aligned.
    assign w_target = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;

    // Next PC and halt detection; a HALT fetched alongside a redirect is wrong-path.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_next_pc    = r_pc;
        w_set_halted = 1'b0;
        if (w_advance) begin
            if (w_redirect) begin
                w_next_pc = w_target;
            end else if (w_is_halt) begin
                w_set_halted = 1'b1;
            end else begin
                w_next_pc = w_pc_plus_4;
            end
        end
    end

    // PC, sticky halt flag and accepted-fetch counter.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_halted      <= 1'b0;
            r_fetch_count <= 32'h0;
        end else begin
            r_pc <= w_next_pc;
            if (w_set_halted) begin
                r_halted <= 1'b1;
            end
            if (w_advance) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    // Loader write port, accepted only while fetch is held.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset so it maps to RAM and program contents survive a pipeline reset.
        if (load_we && !run) begin
            r_mem[load_addr] <= load_data;
        end
    end

    assign if_pc          = r_pc;
    assign if_pc_plus_4   = w_pc_plus_4;
    assign if_instruction = (w_active && !w_is_halt) ? w_mem_word : 32'h0;
    assign flush_ifid     = w_redirect;
    assign halted         = r_halted;
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage.
module tb_if_fetch_stage;

    logic        clk;
    logic        reset;
    logic        run;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        load_we;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;
    logic [31:0] if_instruction;
    logic        flush_ifid;
    logic        halted;
    logic [31:0] fetch_count;

    int n_cmp;
    int n_err;

    if_fetch_stage #(.IMEM_WORDS(256), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .load_we       (load_we),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .if_pc         (if_pc),
        .if_pc_plus_4  (if_pc_plus_4),
        .if_instruction(if_instruction),
        .flush_ifid    (flush_ifid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
        load_we   = 1'b1;
        load_addr = addr;
        load_data = data;
        step();
        load_we   = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b0;
        run           = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        load_we       = 1'b0;
        load_addr     = 8'h0;
        load_data     = 32'h0;

        #2;
        check("rst_pc",     if_pc,                 32'h0);
        check("rst_pc4",    if_pc_plus_4,          32'h4);
        check("rst_halted", {31'h0, halted},       32'h0);
        check("rst_count",  fetch_count,           32'h0);
        check("rst_flush",  {31'h0, flush_ifid},   32'h0);
        check("rst_instr",  if_instruction,        32'h0);
        reset = 1'b1;

        load_word(8'd0,  32'h1111_1111);
        load_word(8'd1,  32'h2222_2222);
        load_word(8'd2,  32'h3333_3333);
        load_word(8'd3,  32'h4444_4444);
        load_word(8'd4,  32'h5555_5555);
        load_word(8'd5,  32'hFFFF_FFFF);
        load_word(8'd16, 32'hAAAA_0010);
        load_word(8'd32, 32'hBBBB_0020);
        check("load_pc_hold",    if_pc,          32'h0);
        check("load_count_hold", fetch_count,    32'h0);
        check("idle_nop",        if_instruction, 32'h0);

        // Start fetching; a loader write while running must be ignored.
        run       = 1'b1;
        load_we   = 1'b1;
        load_addr = 8'd0;
        load_data = 32'hDEAD_BEEF;
        #1;
        check("run_pc0",    if_pc,          32'h0);
        check("run_instr0", if_instruction, 32'h1111_1111);
        step();
        load_we = 1'b0;
        #1;
        check("run_pc4",    if_pc,          32'h4);
        check("run_instr1", if_instruction, 32'h2222_2222);
        check("run_pc4_p4", if_pc_plus_4,   32'h8);
        step();
        check("run_pc8", if_pc,       32'h8);
        check("cnt_2",   fetch_count, 32'd2);

        // Three stalled edges at pc=8; a branch during the stall is ignored.
        stall = 1'b1;
        #1;
        check("stall_instr", if_instruction, 32'h3333_3333);
        step();
        branch_taken  = 1'b1;
        branch_target = 32'h42;
        #1;
        check("stall_no_flush", {31'h0, flush_ifid}, 32'h0);
        step();
        branch_taken = 1'b0;
        check("stall_pc", if_pc, 32'h8);
        step();
        stall = 1'b0;
        #1;
        check("stall_pc_end",  if_pc,       32'h8);
        check("stall_cnt_end", fetch_count, 32'd2);
        step();
        check("pc12", if_pc, 32'hC);
        step();
        check("pc16",       if_pc,          32'h10);
        check("cnt_4",      fetch_count,    32'd4);
        check("instr_pc16", if_instruction, 32'h5555_5555);

        // Jump back to 0: word 0 must not have been overwritten.
        jump        = 1'b1;
        jump_target = 32'h0;
        #1;
        check("jump_flush", {31'h0, flush_ifid}, 32'h1);
        step();
        jump = 1'b0;
        #1;
        check("jump_pc0",       if_pc,          32'h0);
        check("load_ignored",   if_instruction, 32'h1111_1111);
        check("jump_no_flush",  {31'h0, flush_ifid}, 32'h0);
        step();
        check("pc4_again", if_pc, 32'h4);

        // Taken branch with a misaligned target.
        branch_taken  = 1'b1;
        branch_target = 32'h42;
        #1;
        check("br_flush", {31'h0, flush_ifid}, 32'h1);
        step();
        branch_taken = 1'b0;
        #1;
        check("br_pc",    if_pc,          32'h40);
        check("br_instr", if_instruction, 32'hAAAA_0010);
        check("cnt_7",    fetch_count,    32'd7);

        jump        = 1'b1;
        jump_target = 32'h4;
        step();
        // Branch and jump together: jump wins.
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        jump_target   = 32'h80;
        step();
        branch_taken = 1'b0;
        jump         = 1'b0;
        #1;
        check("bj_pc",    if_pc,          32'h80);
        check("bj_instr", if_instruction, 32'hBBBB_0020);
        check("cnt_9",    fetch_count,    32'd9);

        // Land on HALT and redirect in the same cycle: wrong-path HALT.
        jump        = 1'b1;
        jump_target = 32'h14;
        step();
        jump = 1'b0;
        #1;
        check("halt_instr_nop", if_instruction,   32'h0);
        check("halt_not_yet",   {31'h0, halted},  32'h0);
        jump        = 1'b1;
        jump_target = 32'hC;
        #1;
        check("halt_redir_flush", {31'h0, flush_ifid}, 32'h1);
        step();
        jump = 1'b0;
        #1;
        check("halt_redir_pc",     if_pc,           32'hC);
        check("halt_redir_halted", {31'h0, halted}, 32'h0);
        step();
        step();
        check("halt_pc20", if_pc,       32'h14);
        check("cnt_13",    fetch_count, 32'd13);

        // Real HALT.
        step();
        check("halted_set",  {31'h0, halted}, 32'h1);
        check("halted_pc",   if_pc,           32'h14);
        check("halted_cnt",  fetch_count,     32'd14);
        check("halted_nop",  if_instruction,  32'h0);
        step();
        check("frozen_pc",  if_pc,       32'h14);
        check("frozen_cnt", fetch_count, 32'd14);
        run = 1'b0;
        step();
        step();
        run = 1'b1;
        step();
        check("halt_sticky",    {31'h0, halted}, 32'h1);
        check("halt_sticky_pc", if_pc,           32'h14);

        // Asynchronous reset mid-cycle.
        #1;
        reset = 1'b0;
        #1;
        check("areset_pc",     if_pc,           32'h0);
        check("areset_halted", {31'h0, halted}, 32'h0);
        check("areset_cnt",    fetch_count,     32'h0);
        reset = 1'b1;
        #1;
        check("mem_kept", if_instruction, 32'h1111_1111);

        // run 1->0: NOP immediately, PC holds on the edge.
        run = 1'b0;
        #1;
        check("run_off_nop", if_instruction, 32'h0);
        step();
        check("run_off_pc",  if_pc,       32'h0);
        check("run_off_cnt", fetch_count, 32'h0);
        run = 1'b1;

        // Out-of-range fetch.
        jump        = 1'b1;
        jump_target = 32'h400;
        step();
        jump = 1'b0;
        #1;
        check("oor_pc",    if_pc,          32'h400);
        check("oor_instr", if_instruction, 32'h0);
        check("oor_pc4",   if_pc_plus_4,   32'h404);
        step();
        check("oor_next", if_pc,       32'h404);
        check("oor_cnt",  fetch_count, 32'd2);

        // 32-bit PC wrap.
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        #1;
        check("wrap_pc",  if_pc,        32'hFFFF_FFFC);
        check("wrap_pc4", if_pc_plus_4, 32'h0);
        step();
        check("wrap_pc0",   if_pc,          32'h0);
        check("wrap_instr", if_instruction, 32'h1111_1111);
        check("wrap_cnt",   fetch_count,    32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
